// File: rtl/dict_engine_arbiter.sv
// Round-robin arbiter sharing one dictionary compression engine among NUM_REQ requesters.
// Issues one engine command per grant, captures the result, and also sequences dictionary clears.
module dict_engine_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ENG_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [2*NUM_REQ-1:0]    req_cmd,
    input  logic [80*NUM_REQ-1:0]   req_data,
    input  logic [8*NUM_REQ-1:0]    req_code,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2:0]              rsp_id,
    output logic [1:0]              rsp_status,
    output logic [7:0]              rsp_code,
    output logic [79:0]             rsp_data,
    input  logic                    dict_clear,
    output logic                    clear_done,
    output logic                    busy,
    output logic                    eng_reset,
    output logic [1:0]              eng_command,
    output logic [79:0]             eng_data_in,
    output logic [7:0]              eng_compressed_in,
    input  logic [1:0]              eng_response,
    input  logic [7:0]              eng_compressed_out,
    input  logic [79:0]             eng_decompressed_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  r_last_grant;
    logic        r_clear_pending;
    logic [1:0]  r_cmd;
    logic [79:0] r_data;
    logic [7:0]  r_code;
    logic [2:0]  r_id;
    logic [2:0]  r_wait_cnt;
    logic [1:0]  r_rsp_status;
    logic [7:0]  r_rsp_code;
    logic [79:0] r_rsp_data;

    // Payloads are unpacked into fixed 8-entry tables so the winner index is always 3 bits.
    logic [7:0]  w_valid_pad;
    logic [1:0]  w_cmd_arr  [8];
    logic [79:0] w_data_arr [8];
    logic [7:0]  w_code_arr [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slice
            if (gi < NUM_REQ) begin : g_on
                assign w_valid_pad[gi] = req_valid[gi];
                assign w_cmd_arr[gi]   = req_cmd[2*gi +: 2];
                assign w_data_arr[gi]  = req_data[80*gi +: 80];
                assign w_code_arr[gi]  = req_code[8*gi +: 8];
            end else begin : g_off
                assign w_valid_pad[gi] = 1'b0;
                assign w_cmd_arr[gi]   = 2'b00;
                assign w_data_arr[gi]  = '0;
                assign w_code_arr[gi]  = '0;
            end
        end
    endgenerate

    logic       w_found;
    logic [2:0] w_winner;
    logic [3:0] w_idx;

    // Search starts just after the last grant and wraps, giving round-robin fairness.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = {1'b0, r_last_grant} + 4'(k);
            if (w_idx >= 4'(NUM_REQ))
                w_idx = w_idx - 4'(NUM_REQ);
            if (!w_found && w_valid_pad[w_idx[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[2:0];
            end
        end
    end

    logic w_grant;
    assign w_grant = (r_state == S_IDLE) && !r_clear_pending && w_found && !reset;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = w_grant && (w_winner == 3'(gi));
        end
    endgenerate

    logic [1:0] w_win_cmd;
    assign w_win_cmd = w_cmd_arr[w_winner];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_last_grant    <= 3'(NUM_REQ - 1);
            r_clear_pending <= 1'b0;
            r_cmd           <= '0;
            r_data          <= '0;
            r_code          <= '0;
            r_id            <= '0;
            r_wait_cnt      <= '0;
            r_rsp_status    <= '0;
            r_rsp_code      <= '0;
            r_rsp_data      <= '0;
        end else begin
            if (dict_clear)
                r_clear_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_clear_pending) begin
                        // Entering CLEAR absorbs any dict_clear arriving in the same cycle.
                        r_state         <= S_CLEAR;
                        r_clear_pending <= 1'b0;
                    end else if (w_found) begin
                        r_cmd        <= w_win_cmd;
                        r_data       <= w_data_arr[w_winner];
                        r_code       <= w_code_arr[w_winner];
                        r_id         <= w_winner;
                        r_last_grant <= w_winner;
                        if (w_win_cmd == 2'b01 || w_win_cmd == 2'b10) begin
                            r_state <= S_ISSUE;
                        end else begin
                            r_state      <= S_RESP;
                            r_rsp_status <= w_win_cmd;
                            r_rsp_code   <= '0;
                            r_rsp_data   <= '0;
                        end
                    end
                end
                S_CLEAR: r_state <= S_IDLE;
                S_ISSUE: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 3'(ENG_LATENCY - 1)) begin
                        r_rsp_status <= eng_response;
                        r_rsp_code   <= eng_compressed_out;
                        r_rsp_data   <= eng_decompressed_out;
                        r_state      <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid         = (r_state == S_RESP);
    assign rsp_id            = r_id;
    assign rsp_status        = r_rsp_status;
    assign rsp_code          = r_rsp_code;
    assign rsp_data          = r_rsp_data;
    assign clear_done        = (r_state == S_CLEAR);
    assign busy              = (r_state != S_IDLE);
    assign eng_reset         = reset || (r_state == S_CLEAR);
    assign eng_command       = (r_state == S_ISSUE) ? r_cmd : 2'b00;
    assign eng_data_in       = r_data;
    assign eng_compressed_in = r_code;

endmodule

// File: tb/tb_dict_engine_arbiter.sv
// Directed bench for dict_engine_arbiter with a small behavioural dictionary engine
// (16 entries, result registered one cycle after the command).
module tb_dict_engine_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_cmd;
    logic [319:0] req_data;
    logic [31:0]  req_code;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [2:0]   rsp_id;
    logic [1:0]   rsp_status;
    logic [7:0]   rsp_code;
    logic [79:0]  rsp_data;
    logic         dict_clear;
    logic         clear_done;
    logic         busy;
    logic         eng_reset;
    logic [1:0]   eng_command;
    logic [79:0]  eng_data_in;
    logic [7:0]   eng_compressed_in;
    logic [1:0]   eng_response;
    logic [7:0]   eng_compressed_out;
    logic [79:0]  eng_decompressed_out;

    always #5 clk = ~clk;

    dict_engine_arbiter #(.NUM_REQ(4), .ENG_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_data(req_data), .req_code(req_code),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_status(rsp_status), .rsp_code(rsp_code), .rsp_data(rsp_data),
        .dict_clear(dict_clear), .clear_done(clear_done), .busy(busy),
        .eng_reset(eng_reset), .eng_command(eng_command),
        .eng_data_in(eng_data_in), .eng_compressed_in(eng_compressed_in),
        .eng_response(eng_response), .eng_compressed_out(eng_compressed_out),
        .eng_decompressed_out(eng_decompressed_out)
    );

    // Engine model: compress returns the index of the entry (appending if new),
    // decompress returns the stored entry, anything out of range answers 11.
    logic [79:0] m_dict [16];
    int          m_fill;
    int          m_hit;

    always_comb begin
        m_hit = -1;
        for (int j = 0; j < 16; j++)
            if (m_hit < 0 && j < m_fill && m_dict[j] == eng_data_in)
                m_hit = j;
    end

    always @(posedge clk) begin
        if (eng_reset) begin
            m_fill               <= 0;
            eng_response         <= 2'b00;
            eng_compressed_out   <= 8'h00;
            eng_decompressed_out <= '0;
        end else if (eng_command == 2'b01) begin
            eng_decompressed_out <= '0;
            if (m_hit >= 0) begin
                eng_response       <= 2'b01;
                eng_compressed_out <= 8'(m_hit);
            end else if (m_fill < 16) begin
                m_dict[m_fill[3:0]] <= eng_data_in;
                eng_response        <= 2'b01;
                eng_compressed_out  <= 8'(m_fill);
                m_fill              <= m_fill + 1;
            end else begin
                eng_response       <= 2'b11;
                eng_compressed_out <= 8'h00;
            end
        end else if (eng_command == 2'b10) begin
            eng_compressed_out <= 8'h00;
            if (int'(eng_compressed_in) < m_fill) begin
                eng_response         <= 2'b10;
                eng_decompressed_out <= m_dict[eng_compressed_in[3:0]];
            end else begin
                eng_response         <= 2'b11;
                eng_decompressed_out <= '0;
            end
        end
    end

    int eng_cmd_cycles = 0;
    always @(posedge clk)
        if (eng_command != 2'b00)
            eng_cmd_cycles <= eng_cmd_cycles + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        dict_clear = 1'b0;
        #1;
        check("rst_eng_reset", 80'(eng_reset), 80'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(output logic [3:0] g);
        logic done;
        done = 1'b0;
        g    = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (req_ready != 4'b0000) begin
                g    = req_ready;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("grant_timeout", 80'd0, 80'd1);
    endtask

    task automatic wait_rsp();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (rsp_valid) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) check("rsp_timeout", 80'd0, 80'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [1:0] cmd, input logic [79:0] data,
                           input logic [7:0] code);
        req_valid[id]        = 1'b1;
        req_cmd[2*id +: 2]   = cmd;
        req_data[80*id +: 80] = data;
        req_code[8*id +: 8]  = code;
    endtask

    task automatic check_rsp(input string tag, input int id, input logic [1:0] st,
                             input logic [7:0] code, input logic [79:0] data);
        check({tag, "_id"},     80'(rsp_id),     80'(id));
        check({tag, "_status"}, 80'(rsp_status), 80'(st));
        check({tag, "_code"},   80'(rsp_code),   80'(code));
        check({tag, "_data"},   rsp_data,        data);
        $display("txn %s: id=%0d status=%b code=%h data=%h", tag, rsp_id, rsp_status, rsp_code, rsp_data);
    endtask

    // One complete transaction from a lone requester.
    task automatic do_txn(input string tag, input int id, input logic [1:0] cmd,
                          input logic [79:0] data, input logic [7:0] code,
                          input logic [1:0] exp_st, input logic [7:0] exp_code,
                          input logic [79:0] exp_data);
        logic [3:0] g;
        int         cmds0;
        logic       uses_eng;
        uses_eng = (cmd == 2'b01 || cmd == 2'b10);
        @(negedge clk);
        cmds0 = eng_cmd_cycles;
        set_req(id, cmd, data, code);
        wait_grant(g);
        check({tag, "_grant"}, 80'(g), 80'(4'b0001 << id));
        @(negedge clk);
        req_valid[id] = 1'b0;
        #1;
        check({tag, "_eng_cmd"}, 80'(eng_command), uses_eng ? 80'(cmd) : 80'd0);
        wait_rsp();
        check_rsp(tag, id, exp_st, exp_code, exp_data);
        check({tag, "_cmd_cycles"}, 80'(eng_cmd_cycles - cmds0), uses_eng ? 80'd1 : 80'd0);
        finish_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        int         ord   [5] = '{0, 1, 2, 3, 0};
        logic [7:0] codes [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};

        reset      = 1'b1;
        req_valid  = '0;
        req_cmd    = '0;
        req_data   = '0;
        req_code   = '0;
        rsp_ready  = 1'b0;
        dict_clear = 1'b0;
        do_reset();

        // Quiescent outputs after reset.
        #1;
        check("idle_busy",       80'(busy),        80'd0);
        check("idle_rsp_valid",  80'(rsp_valid),   80'd0);
        check("idle_req_ready",  80'(req_ready),   80'd0);
        check("idle_eng_cmd",    80'(eng_command), 80'd0);
        check("idle_eng_reset",  80'(eng_reset),   80'd0);
        check("idle_clear_done", 80'(clear_done),  80'd0);
        check("idle_rsp_status", 80'(rsp_status),  80'd0);

        // Single compress into an empty dictionary.
        do_txn("single", 2, 2'b01, 80'h1234, 8'h00, 2'b01, 8'h00, 80'h0);

        // Round robin with all four requesters holding.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 2'b01, 80'hA0 + 80'(i), 8'h00);
        for (int n = 0; n < 5; n++) begin
            wait_grant(g);
            check("rr_grant", 80'(g), 80'(4'b0001 << ord[n]));
            @(negedge clk);
            if (n > 0) req_valid[ord[n]] = 1'b0;
            wait_rsp();
            check_rsp("rr", ord[n], 2'b01, codes[n], 80'h0);
            finish_rsp();
        end

        // Decompress hit and out-of-range code.
        do_reset();
        do_txn("fill0", 0, 2'b01, 80'hBEEF_0000, 8'h00, 2'b01, 8'h00, 80'h0);
        do_txn("fill1", 0, 2'b01, 80'hBEEF_1111, 8'h00, 2'b01, 8'h01, 80'h0);
        do_txn("fill2", 0, 2'b01, 80'hBEEF_2222, 8'h00, 2'b01, 8'h02, 80'h0);
        do_txn("decomp", 1, 2'b10, 80'h0, 8'h01, 2'b10, 8'h00, 80'hBEEF_1111);
        do_txn("decerr", 1, 2'b10, 80'h0, 8'h05, 2'b11, 8'h00, 80'h0);

        // Local commands never touch the engine.
        do_txn("nop", 2, 2'b00, 80'h55, 8'h00, 2'b00, 8'h00, 80'h0);
        do_txn("inv", 3, 2'b11, 80'h66, 8'h00, 2'b11, 8'h00, 80'h0);

        // Backpressure, then a clear that takes priority over a waiting request.
        do_reset();
        do_txn("bp_a", 0, 2'b01, 80'hC0, 8'h00, 2'b01, 8'h00, 80'h0);
        do_txn("bp_b", 0, 2'b01, 80'hC1, 8'h00, 2'b01, 8'h01, 80'h0);
        @(negedge clk);
        set_req(3, 2'b01, 80'hC3, 8'h00);
        wait_grant(g);
        check("bp_grant3", 80'(g), 80'b1000);
        @(negedge clk);
        req_valid[3] = 1'b0;
        set_req(1, 2'b01, 80'hD1, 8'h00);
        wait_rsp();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            dict_clear = (c == 2);
            #1;
            check("bp_rsp_valid", 80'(rsp_valid), 80'd1);
            check("bp_rsp_id",    80'(rsp_id),    80'd3);
            check("bp_rsp_code",  80'(rsp_code),  80'd2);
            check("bp_req_ready", 80'(req_ready), 80'd0);
        end
        @(negedge clk);
        dict_clear = 1'b0;
        finish_rsp();
        #1;
        check("clr_idle_ready", 80'(req_ready),  80'd0);
        check("clr_idle_busy",  80'(busy),       80'd0);
        check("clr_idle_erst",  80'(eng_reset),  80'd0);
        @(negedge clk);
        #1;
        check("clr_eng_reset",  80'(eng_reset),  80'd1);
        check("clr_done",       80'(clear_done), 80'd1);
        check("clr_ready",      80'(req_ready),  80'd0);
        @(negedge clk);
        #1;
        check("clr_after_erst", 80'(eng_reset),  80'd0);
        check("clr_after_done", 80'(clear_done), 80'd0);
        check("clr_after_grant", 80'(req_ready), 80'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp();
        check_rsp("clr_fresh", 1, 2'b01, 8'h00, 80'h0);
        finish_rsp();

        // Reset while waiting on the engine abandons the transaction.
        do_reset();
        @(negedge clk);
        set_req(2, 2'b01, 80'hE2, 8'h00);
        wait_grant(g);
        check("mid_grant2", 80'(g), 80'b0100);
        @(negedge clk);
        req_valid[2] = 1'b0;
        #1;
        check("mid_issue_cmd", 80'(eng_command), 80'd1);
        @(negedge clk);
        #1;
        check("mid_wait_busy", 80'(busy),        80'd1);
        check("mid_wait_cmd",  80'(eng_command), 80'd0);
        reset = 1'b1;
        #1;
        check("mid_eng_reset", 80'(eng_reset), 80'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("mid_no_rsp",  80'(rsp_valid), 80'd0);
            check("mid_no_busy", 80'(busy),      80'd0);
            @(negedge clk);
        end
        set_req(0, 2'b01, 80'hF0, 8'h00);
        set_req(3, 2'b01, 80'hF3, 8'h00);
        wait_grant(g);
        check("mid_first0", 80'(g), 80'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp();
        check_rsp("mid_r0", 0, 2'b01, 8'h00, 80'h0);
        finish_rsp();
        wait_grant(g);
        check("mid_then3", 80'(g), 80'b1000);
        @(negedge clk);
        req_valid[3] = 1'b0;
        wait_rsp();
        check_rsp("mid_r3", 3, 2'b01, 8'h01, 80'h0);
        finish_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dict_engine_arbiter.md
Name: dict_engine_arbiter

Overview:
- Shares one dictionary compression/decompression engine among NUM_REQ requesters.
- Each requester presents a valid/ready request. The block arbitrates round-robin, issues exactly one engine command per grant, waits the engine latency, and returns the captured result on a shared response channel with backpressure.
- It also sequences dictionary-clear operations: it drives the engine reset when idle, on request.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ENG_LATENCY, 1, cycles between the command cycle and the cycle whose end samples the engine result (1..7).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot accept pulse
- req_cmd  in  2*NUM_REQ  per-requester command, slice i = [2i+1:2i]: 00 nop, 01 compress, 10 decompress, 11 invalid
- req_data  in  80*NUM_REQ  per-requester data to compress
- req_code  in  8*NUM_REQ  per-requester code to decompress
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  3  index of the served requester
- rsp_status  out  2  00 nop, 01 compressed, 10 decompressed, 11 error
- rsp_code  out  8  captured compressed code
- rsp_data  out  80  captured decompressed data
- dict_clear  in  1  single-cycle request to empty the dictionary
- clear_done  out  1  one-cycle pulse when a clear has been issued
- busy  out  1  high whenever the state is not IDLE
- eng_reset  out  1  engine reset
- eng_command  out  2  engine command
- eng_data_in  out  80  engine data input
- eng_compressed_in  out  8  engine code input
- eng_response  in  2  engine response
- eng_compressed_out  in  8  engine code output
- eng_decompressed_out  in  80  engine data output

Behaviour:
- Reset:
  - State goes to IDLE. All registered outputs go to 0. last_grant = NUM_REQ-1, so requester 0 wins first. clear_pending = 0.
  - Any in-flight transaction is abandoned with no response.
  - eng_reset = reset OR (state==CLEAR), combinational, so the engine dictionary is also cleared during reset.
- Engine drive:
  - eng_command = latched cmd only in ISSUE, otherwise 00.
  - eng_data_in and eng_compressed_in hold the latched values from ISSUE through the end of WAIT.
- clear_pending:
  - Set by dict_clear in any state. A dict_clear arriving while already pending is merged.
  - Cleared on entering CLEAR.
- IDLE:
  - If clear_pending is set, go to CLEAR. Clear has priority over requests.
  - Otherwise, if any req_valid is set, choose the winner by searching from last_grant+1 upward with wrap-around.
  - Assert req_ready[winner] for this cycle only. Latch cmd, data, code and id. Set last_grant = winner.
  - Next state is ISSUE if cmd is 01 or 10. For 00 or 11, go straight to RESP with status = cmd, code = 0, data = 0; the engine is not accessed.
- CLEAR: one cycle; eng_reset = 1, clear_done = 1; next state IDLE.
- ISSUE: one cycle driving the command; next state WAIT with wait_cnt = 0.
- WAIT:
  - eng_command = 00.
  - When wait_cnt == ENG_LATENCY-1, capture eng_response, eng_compressed_out and eng_decompressed_out into the rsp_* registers at the clock edge, and go to RESP.
  - Otherwise wait_cnt increments.
- RESP:
  - rsp_valid = 1. rsp_* stay stable until rsp_valid && rsp_ready.
  - On handshake, go to IDLE. The next grant can occur no earlier than the following cycle.
- Engine error: engine response 11 (dictionary full, or code above the fill index) is forwarded unchanged as rsp_status 11. The arbiter retries nothing.
- Fairness: no requester is granted twice while another requester holds req_valid continuously.
- Request hold rule: requesters hold valid and payload until ready. A valid that drops before grant is simply not served.
- Throughput: a requester not winning arbitration is never dropped. Worst-case service is 3+ENG_LATENCY cycles per grant plus response stall.

Test Plan:
- Single request, compress: requester 2 sends cmd 01, data 80'h1234 into an empty engine → req_ready[2] in IDLE, eng_command=01 one cycle later, rsp_valid with id 2, status 01, code 8'h00.
- Round-robin: all four hold cmd 01 with distinct data → grants in order 0,1,2,3,0. Codes 0,1,2,3 come back, and the fifth request (same data as requester 0) returns code 0.
- Decompress and error: compress 3 values, then requester 1 sends cmd 10 code 1 → status 10, data = second value. Code 8'h05 → status 11.
- Local commands: cmd 00 → status 00; cmd 11 → status 11. For both, eng_command stays 00 throughout.
- Backpressure and clear: hold rsp_ready=0 for 5 cycles → rsp_* stable, no new req_ready. Pulse dict_clear during RESP, then release → CLEAR follows IDLE before the pending request, with eng_reset=1 for one cycle and clear_done pulsed. A subsequent compress returns code 0.
- Reset mid-WAIT: assert reset during WAIT → no rsp_valid. State, outputs and grant pointer are reset. The next request from requester 0 is served first.
